tlul_host_arbiter: RTL and testbench
====================================

# tlul_host_arbiter

Shares one TL-UL host port among `N_HOSTS` simple req/gnt/valid masters (the same host-side contract as the TL-UL host adapter). It sits between several host agents (core fetch, core LSU, debug, DMA) and the crossbar, and handles four jobs:
- round-robin arbitration of channel A, holding A stable under back-pressure;
- tagging each request's `a_source` with the winner index;
- routing channel-D responses back to the issuing host by `d_source`;
- enforcing a per-host outstanding-request limit.

## Interface
Parameters:
- `N_HOSTS`, default 2: number of requesters, range 2..2^TL_AIW.
- `MAX_OUTSTANDING`, default 2: maximum in-flight requests per host, at least 1.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in N_HOSTS: request per host. The host holds it, with its request fields stable, until `gnt_o`.
- `gnt_o` out N_HOSTS: one-hot grant. The request is accepted on a cycle where `req_i[i] & gnt_o[i]`.
- `addr_i` in N_HOSTS*TL_AW: per-host address, packed with host 0 in the LSBs.
- `we_i` in N_HOSTS: write enable.
- `wdata_i` in N_HOSTS*TL_DW: write data.
- `be_i` in N_HOSTS*TL_DBW: byte enables.
- `valid_o` out N_HOSTS: one-hot response strobe.
- `rdata_o` out TL_DW: response data, broadcast to all hosts. It is qualified only by `valid_o[i]`.
- `err_o` out N_HOSTS: response error, qualified by `valid_o[i]`.
- `tl_h_c_a` out tl_h2d_t: channel A to the fabric, with `d_ready` included.
- `tl_h_c_d` in tl_d2h_t: channel D from the fabric, with `a_ready` included.

## Operation
- Eligibility: host i is eligible when `req_i[i]` is high and `cnt[i] < MAX_OUTSTANDING`.
- Arbitration: round-robin. The search starts at pointer `rr_q` and wraps from N_HOSTS-1 to 0.
- Pointer update: on an accept, `rr_q <= winner+1`, wrapping to 0 past N_HOSTS-1.
- FSM `IDLE`:
  - The winner is chosen combinationally, and `a_valid` follows immediately.
  - If `a_ready` is high, the request is accepted and the FSM stays in `IDLE`.
  - If `a_ready` is low with a winner present, the winner is latched into `own_q` and the FSM goes to `HOLD`.
- FSM `HOLD`:
  - `a_valid=1` and all A fields come from host `own_q`. No re-arbitration takes place.
  - On `a_ready`, the request is accepted, `rr_q` is updated and the FSM returns to `IDLE`.
- Channel A field encoding:
  - `a_opcode`: Get when `we=0`. When `we=1`, PutFullData if all `be` bits are set, otherwise PutPartialData.
  - `a_mask`: all ones for reads, `be` for writes.
  - `a_size`: `clog2(TL_DBW)`.
  - `a_address`: word-aligned, with the low `clog2(TL_DBW)` bits forced to 0.
  - `a_param`: 0.
  - `a_source`: the winner index, zero-extended to TL_AIW.
- `d_ready` is tied to 1.
- Response routing: on `d_valid`, index `k = d_source[IDXW-1:0]`.
  - If `k < N_HOSTS` and `cnt[k] > 0`: `valid_o[k]=1` and `cnt[k]` decrements.
  - Otherwise the beat is dropped silently. There is no counter underflow.
- Counter update:
  - An accept and a response for the same host in the same cycle leave `cnt` unchanged.
  - The counter width is `clog2(MAX_OUTSTANDING+1)`.
- Ordering: responses to a single host are assumed to return in order. No reordering is performed.

## Timing
- Reset values: `rr_q=0`, all `cnt=0`, state `IDLE`, `own_q=0`.
- Outputs under reset: `gnt_o=0`, `valid_o=0`, `err_o=0`, `a_valid=0`.
- Reset mid-operation:
  - Outstanding counts are discarded.
  - Late D beats are dropped, because all counters are 0 after reset.
- Request path is zero-latency: `req_i` to `a_valid` and `gnt_o` is combinational. `gnt_o = a_ready & selected`.
- Response path is zero-latency: `d_valid` to `valid_o`, `rdata_o` and `err_o` is combinational.
- `a_valid` never deasserts and A fields never change while in `HOLD`.
- A granted host may re-request on the next cycle. Its next win depends on the round-robin order and its `cnt`.
- At most one accept and one response per cycle.

## Configuration
- Macro: `TLUL_HOST_ARB_ERR_EN`.
- Defined: `err_o[k] = d_error`, on routed responses only.
- Undefined: `err_o` is tied to 0, and `d_error` is ignored.

## Structure
- Shared package: tl_h2d_t/tl_d2h_t, the opcodes, and the TL_AW/TL_DW/TL_DBW/TL_AIW widths all stay in `tlul_pkg`. A `tlul_arb_state_e` enum (IDLE, HOLD) is added to `tlul_pkg`.
- Sub-module: `tlul_rr_arb`, the round-robin pick.
  - Inputs: eligible vector, `rr_q`.
  - Outputs: one-hot winner, index, any-valid.
  - Purely combinational, parameterised by N.

## Test plan
- Two hosts request reads simultaneously with `a_ready=1`: host 0 is granted in cycle 0 and host 1 in cycle 1, with `a_source` 0 then 1 and `a_mask=4'hF`.
- Host 1 writes `be=4'b0011` to addr 0x1003 with `a_ready` low for 3 cycles while host 0 starts requesting: A holds host 1's request (PutPartialData, address 0x1000) for 4 cycles. Grant then goes to host 1, then host 0.
- `MAX_OUTSTANDING=2`, host 0 issues 3 reads with no responses: the 3rd read is not granted. After a D beat with source 0, the 3rd read is granted the following cycle.
- D beat with source 1 and `d_data=0xDEADBEEF`: `valid_o=2'b10` and `rdata_o=0xDEADBEEF`. A beat with source 3 when N=2 produces no `valid_o` and no counter change.
- Same-cycle accept and response for host 0 with `cnt=1`: `cnt` stays 1.
- With `TLUL_HOST_ARB_ERR_EN` defined, `d_error=1` gives `err_o[k]=1`. Without the macro, `err_o` stays 0.
- Reset asserted in `HOLD`: the next cycle shows `a_valid=0`, and a later D beat is dropped.

Source files
------------

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL widths, opcodes, channel structs and arbiter state enum
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;

    // Byte-offset bits inside one data word; forced to zero on a_address.
    localparam int TL_ADDR_LSB = $clog2(TL_DBW);

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                  a_valid;
        tl_a_op_e              a_opcode;
        logic [2:0]            a_param;
        logic [TL_SZW-1:0]     a_size;
        logic [TL_AIW-1:0]     a_source;
        logic [TL_AW-1:0]      a_address;
        logic [TL_DBW-1:0]     a_mask;
        logic [TL_DW-1:0]      a_data;
        logic                  d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                  d_valid;
        tl_d_op_e              d_opcode;
        logic [2:0]            d_param;
        logic [TL_SZW-1:0]     d_size;
        logic [TL_AIW-1:0]     d_source;
        logic [TL_DIW-1:0]     d_sink;
        logic [TL_DW-1:0]      d_data;
        logic                  d_error;
        logic                  a_ready;
    } tl_d2h_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tlul_arb_state_e;

endpackage

// File: rtl/tlul_rr_arb.sv
// rtl/tlul_rr_arb.sv - combinational round-robin pick starting at a pointer
module tlul_rr_arb #(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    elig_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    win_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    // Scan from ptr_i upward, wrapping past N-1; first eligible requester wins.
    always_comb begin
        int j;
        j     = 0;
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr_i) + off) % N;
            if (!any_o && elig_i[j]) begin
                any_o    = 1'b1;
                win_o[j] = 1'b1;
                idx_o    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// rtl/tlul_host_arbiter.sv - N-host round-robin TL-UL arbiter; optional TLUL_HOST_ARB_ERR_EN
module tlul_host_arbiter
    import tlul_pkg::*;
#(
    parameter int N_HOSTS         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_HOSTS-1:0]        req_i,
    output logic [N_HOSTS-1:0]        gnt_o,
    input  logic [N_HOSTS*TL_AW-1:0]  addr_i,
    input  logic [N_HOSTS-1:0]        we_i,
    input  logic [N_HOSTS*TL_DW-1:0]  wdata_i,
    input  logic [N_HOSTS*TL_DBW-1:0] be_i,
    output logic [N_HOSTS-1:0]        valid_o,
    output logic [TL_DW-1:0]          rdata_o,
    output logic [N_HOSTS-1:0]        err_o,
    output tl_h2d_t                   tl_h_c_a,
    input  tl_d2h_t                   tl_h_c_d
);

    localparam int IDXW = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_OUTSTANDING);

    tlul_arb_state_e   state_q, state_d;
    logic [IDXW-1:0]   rr_q, rr_d, own_q, own_d;
    logic [CNTW-1:0]   cnt_q [N_HOSTS];
    logic [CNTW-1:0]   cnt_d [N_HOSTS];

    logic [N_HOSTS-1:0] elig, arb_win, sel_oh;
    logic [IDXW-1:0]    arb_idx, sel_idx, d_idx;
    logic               arb_any, a_valid, accept;
    logic [TL_AW-1:0]   sel_addr;
    logic [TL_DBW-1:0]  sel_be;
    logic               sel_we;
    logic               unused_d;

    // A host competes only while it is below its in-flight limit.
    always_comb begin
        for (int i = 0; i < N_HOSTS; i++) begin
            elig[i] = req_i[i] && (cnt_q[i] < MAX_CNT);
        end
    end

    tlul_rr_arb #(.N(N_HOSTS), .IDXW(IDXW)) u_rr_arb (
        .elig_i (elig),
        .ptr_i  (rr_q),
        .win_o  (arb_win),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // Drive channel A from the current owner: the live winner in IDLE, own_q in HOLD.
    always_comb begin
        sel_oh = '0;
        if (state_q == HOLD) begin
            sel_idx        = own_q;
            sel_oh[own_q]  = 1'b1;
        end else begin
            sel_idx = arb_idx;
            sel_oh  = arb_win;
        end
        a_valid  = !rst_i && ((state_q == HOLD) || arb_any);
        accept   = a_valid && tl_h_c_d.a_ready;
        gnt_o    = accept ? sel_oh : '0;
        sel_addr = addr_i[int'(sel_idx)*TL_AW +: TL_AW];
        sel_be   = be_i[int'(sel_idx)*TL_DBW +: TL_DBW];
        sel_we   = we_i[sel_idx];

        tl_h_c_a           = '0;
        tl_h_c_a.a_valid   = a_valid;
        tl_h_c_a.a_opcode  = !sel_we ? Get : ((&sel_be) ? PutFullData : PutPartialData);
        tl_h_c_a.a_param   = 3'h0;
        tl_h_c_a.a_size    = TL_SZW'(TL_ADDR_LSB);
        tl_h_c_a.a_source  = TL_AIW'(sel_idx);
        tl_h_c_a.a_address = {sel_addr[TL_AW-1:TL_ADDR_LSB], {TL_ADDR_LSB{1'b0}}};
        tl_h_c_a.a_mask    = sel_we ? sel_be : {TL_DBW{1'b1}};
        tl_h_c_a.a_data    = wdata_i[int'(sel_idx)*TL_DW +: TL_DW];
        tl_h_c_a.d_ready   = 1'b1;
    end

    // Route a D beat to its host only if that host really has something in flight.
    always_comb begin
        d_idx   = tl_h_c_d.d_source[IDXW-1:0];
        valid_o = '0;
        err_o   = '0;
        rdata_o = tl_h_c_d.d_data;
        if (!rst_i && tl_h_c_d.d_valid && (int'(d_idx) < N_HOSTS)) begin
            if (cnt_q[d_idx] != '0) begin
                valid_o[d_idx] = 1'b1;
`ifdef TLUL_HOST_ARB_ERR_EN
                err_o[d_idx]   = tl_h_c_d.d_error;
`endif
            end
        end
    end

`ifdef TLUL_HOST_ARB_ERR_EN
    assign unused_d = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param, tl_h_c_d.d_size,
                        tl_h_c_d.d_sink, tl_h_c_d.d_source};
`else
    assign unused_d = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param, tl_h_c_d.d_size,
                        tl_h_c_d.d_sink, tl_h_c_d.d_source, tl_h_c_d.d_error};
`endif

    // Next state: park in HOLD when the fabric stalls, advance the pointer past each accept.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (arb_any && !tl_h_c_d.a_ready) begin
                    own_d   = arb_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (tl_h_c_d.a_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            rr_d = (int'(sel_idx) == N_HOSTS - 1) ? '0 : sel_idx + 1'b1;
        end
    end

    // In-flight counters: accept and response on the same host cancel out.
    always_comb begin
        for (int i = 0; i < N_HOSTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt_o[i] && !valid_o[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (valid_o[i] && !gnt_o[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // State registers with synchronous reset discarding all in-flight bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            own_q   <= '0;
            rr_q    <= '0;
            for (int i = 0; i < N_HOSTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            for (int i = 0; i < N_HOSTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// tb/tb_tlul_host_arbiter.sv - directed self-checking bench for tlul_host_arbiter
module tb_tlul_host_arbiter;
    import tlul_pkg::*;

`ifdef TLUL_HOST_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       req_i;
    logic [1:0]       gnt_o;
    logic [63:0]      addr_i;
    logic [1:0]       we_i;
    logic [63:0]      wdata_i;
    logic [7:0]       be_i;
    logic [1:0]       valid_o;
    logic [31:0]      rdata_o;
    logic [1:0]       err_o;
    tl_h2d_t          tl_a;
    tl_d2h_t          tl_d;

    logic             d_valid, d_err, a_rdy;
    logic [7:0]       d_src;
    logic [31:0]      d_data;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        tl_d          = '0;
        tl_d.d_valid  = d_valid;
        tl_d.d_source = d_src;
        tl_d.d_data   = d_data;
        tl_d.d_error  = d_err;
        tl_d.d_opcode = AccessAckData;
        tl_d.a_ready  = a_rdy;
    end

    tlul_host_arbiter #(.N_HOSTS(2), .MAX_OUTSTANDING(2)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
        .valid_o  (valid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .tl_h_c_a (tl_a),
        .tl_h_c_d (tl_d)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic dbeat(input logic [7:0] src, input logic [31:0] data, input logic err);
        d_valid = 1'b1;
        d_src   = src;
        d_data  = data;
        d_err   = err;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 2'b11; we_i = 2'b00; addr_i = '0; wdata_i = '0; be_i = '0;
        a_rdy = 1'b1; d_valid = 1'b0; d_src = '0; d_data = '0; d_err = 1'b0;
        dbeat(8'd0, 32'h5555_5555, 1'b1);
        smp();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_avalid", tl_a.a_valid, 1'b0);
        chk("rst_valid", valid_o, 2'b00);
        chk("rst_err", err_o, 2'b00);
        cyc(); cyc();

        // Two simultaneous reads: host 0 then host 1.
        rst_i = 1'b0; d_valid = 1'b0; d_err = 1'b0;
        req_i = 2'b11; addr_i = {32'h0000_0204, 32'h0000_0100};
        smp();
        chk("t1_gnt0", gnt_o, 2'b01);
        chk("t1_src0", tl_a.a_source, 8'd0);
        chk("t1_mask", tl_a.a_mask, 4'hF);
        chk("t1_op_get", tl_a.a_opcode, 3'h4);
        chk("t1_addr0", tl_a.a_address, 32'h100);
        chk("t1_size", tl_a.a_size, 2'd2);
        chk("t1_dready", tl_a.d_ready, 1'b1);
        cyc(); req_i = 2'b10;
        smp();
        chk("t1_gnt1", gnt_o, 2'b10);
        chk("t1_src1", tl_a.a_source, 8'd1);
        chk("t1_addr1", tl_a.a_address, 32'h204);
        cyc(); req_i = 2'b00; dbeat(8'd1, 32'hDEAD_BEEF, 1'b0);
        smp();
        chk("d1_valid", valid_o, 2'b10);
        chk("d1_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("d1_avalid_idle", tl_a.a_valid, 1'b0);
        cyc(); dbeat(8'd3, 32'h1234_5678, 1'b0);
        smp();
        chk("d3_dropped", valid_o, 2'b00);
        cyc(); dbeat(8'd0, 32'h1111_1111, 1'b1);
        smp();
        chk("d0_valid", valid_o, 2'b01);
        chk("d0_err", err_o, ERR_EN ? 2'b01 : 2'b00);
        cyc(); dbeat(8'd0, 32'h2222_2222, 1'b1);
        smp();
        chk("d0_underflow", valid_o, 2'b00);
        chk("d0_underflow_err", err_o, 2'b00);
        cyc(); d_valid = 1'b0; d_err = 1'b0;

        // Host 1 partial write held under back-pressure, then host 0 read.
        req_i = 2'b10; we_i = 2'b10; be_i = 8'b0011_0000; a_rdy = 1'b0;
        addr_i = {32'h0000_1003, 32'h0000_0040}; wdata_i = {32'h1234_5678, 32'h0};
        smp();
        chk("t2_avalid", tl_a.a_valid, 1'b1);
        chk("t2_src", tl_a.a_source, 8'd1);
        chk("t2_op_partial", tl_a.a_opcode, 3'h1);
        chk("t2_addr", tl_a.a_address, 32'h1000);
        chk("t2_mask", tl_a.a_mask, 4'h3);
        chk("t2_nogrant", gnt_o, 2'b00);
        cyc(); req_i = 2'b11;
        smp();
        chk("t2_hold1_avalid", tl_a.a_valid, 1'b1);
        chk("t2_hold1_src", tl_a.a_source, 8'd1);
        chk("t2_hold1_addr", tl_a.a_address, 32'h1000);
        cyc();
        smp();
        chk("t2_hold2_src", tl_a.a_source, 8'd1);
        chk("t2_hold2_op", tl_a.a_opcode, 3'h1);
        cyc(); a_rdy = 1'b1;
        smp();
        chk("t2_gnt1", gnt_o, 2'b10);
        chk("t2_src_acc", tl_a.a_source, 8'd1);
        chk("t2_data", tl_a.a_data, 32'h1234_5678);
        cyc(); req_i = 2'b01;
        smp();
        chk("t2_gnt0", gnt_o, 2'b01);
        chk("t2_src0", tl_a.a_source, 8'd0);
        chk("t2_op0", tl_a.a_opcode, 3'h4);
        chk("t2_addr0", tl_a.a_address, 32'h40);
        cyc(); req_i = 2'b00; we_i = 2'b00; dbeat(8'd1, 32'h0, 1'b0);
        smp();
        chk("t2_d1", valid_o, 2'b10);
        cyc(); dbeat(8'd0, 32'h0, 1'b0);
        smp();
        chk("t2_d0", valid_o, 2'b01);
        cyc(); d_valid = 1'b0;

        // Host 0 full write: PutFullData, address aligned.
        req_i = 2'b01; we_i = 2'b01; be_i = 8'h0F;
        addr_i = {32'h0, 32'h0000_2007}; wdata_i = {32'h0, 32'hCAFE_F00D};
        smp();
        chk("tw_gnt", gnt_o, 2'b01);
        chk("tw_op_full", tl_a.a_opcode, 3'h0);
        chk("tw_addr", tl_a.a_address, 32'h2004);
        chk("tw_mask", tl_a.a_mask, 4'hF);
        chk("tw_data", tl_a.a_data, 32'hCAFE_F00D);
        cyc(); req_i = 2'b00; we_i = 2'b00; dbeat(8'd0, 32'h0, 1'b0);
        smp();
        chk("tw_d0", valid_o, 2'b01);
        cyc(); d_valid = 1'b0;

        // Outstanding limit on host 0.
        req_i = 2'b01; addr_i = {32'h0, 32'h0000_0080};
        smp();
        chk("t3_rd1", gnt_o, 2'b01);
        cyc();
        smp();
        chk("t3_rd2", gnt_o, 2'b01);
        cyc();
        smp();
        chk("t3_rd3_blocked", gnt_o, 2'b00);
        chk("t3_rd3_avalid", tl_a.a_valid, 1'b0);
        cyc(); dbeat(8'd0, 32'h0, 1'b0);
        smp();
        chk("t3_resp_valid", valid_o, 2'b01);
        chk("t3_resp_still_blocked", gnt_o, 2'b00);
        cyc(); d_valid = 1'b0;
        smp();
        chk("t3_rd3_granted", gnt_o, 2'b01);
        cyc(); req_i = 2'b00; dbeat(8'd0, 32'h0, 1'b0);
        smp();
        chk("t3_drain", valid_o, 2'b01);
        // cnt0 is 1: accept and response together must leave it at 1.
        cyc(); req_i = 2'b01;
        smp();
        chk("t4_same_gnt", gnt_o, 2'b01);
        chk("t4_same_valid", valid_o, 2'b01);
        cyc(); d_valid = 1'b0;
        smp();
        chk("t4_one_more", gnt_o, 2'b01);
        cyc();
        smp();
        chk("t4_full", gnt_o, 2'b00);
        cyc(); req_i = 2'b00; dbeat(8'd0, 32'h0, 1'b0);
        smp();
        chk("t4_drain1", valid_o, 2'b01);
        cyc();
        smp();
        chk("t4_drain2", valid_o, 2'b01);
        cyc(); d_valid = 1'b0;

        // Reset while holding host 1; host 0 left one request in flight.
        req_i = 2'b01;
        smp();
        chk("t5_gnt0", gnt_o, 2'b01);
        cyc(); req_i = 2'b10; a_rdy = 1'b0;
        smp();
        chk("t5_avalid", tl_a.a_valid, 1'b1);
        chk("t5_src1", tl_a.a_source, 8'd1);
        cyc(); rst_i = 1'b1; a_rdy = 1'b1;
        smp();
        chk("t5_rst_avalid", tl_a.a_valid, 1'b0);
        chk("t5_rst_gnt", gnt_o, 2'b00);
        cyc(); rst_i = 1'b0; req_i = 2'b00;
        smp();
        chk("t5_post_avalid", tl_a.a_valid, 1'b0);
        cyc(); dbeat(8'd0, 32'h0, 1'b0);
        smp();
        chk("t5_late_d_dropped", valid_o, 2'b00);
        cyc(); d_valid = 1'b0; req_i = 2'b11;
        smp();
        chk("t5_rr_reset", gnt_o, 2'b01);
        cyc(); req_i = 2'b00;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
